// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo load path.
//   TAG_W / REG_W / DATA_W / ADDR_W : widths of station tags, register ids,
//                                     data words and effective addresses
//   load_req_t                      : one queued load {tag, dest, addr}
//   lsu_state_e                     : load unit FSM states
package tomasulo_pkg;

   localparam int TAG_W  = 4;
   localparam int REG_W  = 3;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [REG_W-1:0]  dest;
      logic [ADDR_W-1:0] addr;
   } load_req_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      BROADCAST
   } lsu_state_e;

endpackage

// File: rtl/load_request_fifo.sv
// In-order request buffer between the load reservation station and the
// memory-access FSM.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : enqueue data_i (ignored when full)
//   data_i       : request to enqueue
//   pop_i        : dequeue head (ignored when empty)
//   data_o       : current head entry (valid while !empty_o)
//   full_o       : no free entries
//   empty_o      : no entries
//   count_o      : entries in use
module load_request_fifo
   import tomasulo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  load_req_t                data_i,
   input  logic                     pop_i,
   output load_req_t                data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

   load_req_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // Fullness comes from the registered count, so a push while full is
   // dropped even when a pop frees a slot at the same edge.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage carries data only and needs no reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/load_memory_unit.sv
// Memory-access stage for issued loads. Buffers requests in order, reads a
// local data memory with fixed latency and broadcasts each result on the
// CDB under a request/grant handshake.
//   clock, reset                     : clock, synchronous active-high reset
//   requestEnable/Register/Address/Tag : incoming load request
//   requestReady                     : buffer not full
//   memWriteEnable/Addr/Data         : preload/store write port
//   cdbRequest, cdbGrant             : CDB arbiter handshake
//   cdbTag, cdbDest, cdbData         : broadcast result (zero when idle)
//   occupancy                        : buffered requests
//   overflow                         : sticky, push attempted while full
module load_memory_unit
   import tomasulo_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_BITS   = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          requestEnable,
   input  logic [2:0]                    requestRegister,
   input  logic [15:0]                   requestAddress,
   input  logic [3:0]                    requestTag,
   output logic                          requestReady,
   input  logic                          memWriteEnable,
   input  logic [ADDR_BITS-1:0]          memWriteAddr,
   input  logic [15:0]                   memWriteData,
   output logic                          cdbRequest,
   input  logic                          cdbGrant,
   output logic [3:0]                    cdbTag,
   output logic [2:0]                    cdbDest,
   output logic [15:0]                   cdbData,
   output logic [$clog2(FIFO_DEPTH):0]   occupancy,
   output logic                          overflow
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0]    mem_q [2**ADDR_BITS];

   lsu_state_e           state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [TAG_W-1:0]     cur_tag_q;
   logic [REG_W-1:0]     cur_dest_q;
   logic [ADDR_BITS-1:0] cur_addr_q;
   logic                 req_q;
   logic [TAG_W-1:0]     cdb_tag_q;
   logic [REG_W-1:0]     cdb_dest_q;
   logic [DATA_W-1:0]    cdb_data_q;
   logic                 overflow_q;

   load_req_t            push_req;
   load_req_t            head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 unused_addr_hi;

   assign push_req.tag  = requestTag;
   assign push_req.dest = requestRegister;
   assign push_req.addr = requestAddress;

   // Address bits above the memory index are carried but never used.
   assign unused_addr_hi = ^head.addr[ADDR_W-1:ADDR_BITS];

   // Pop from IDLE, or at a granted broadcast so the next load goes
   // straight back into ACCESS. req_q is always set in BROADCAST, so a
   // grant without a pending request never reaches this term.
   assign pop = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == BROADCAST) && cdbGrant));

   load_request_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (requestEnable),
      .data_i  (push_req),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (occupancy)
   );

   assign requestReady = !fifo_full;
   assign overflow     = overflow_q;
   assign cdbRequest   = req_q;
   assign cdbTag       = cdb_tag_q;
   assign cdbDest      = cdb_dest_q;
   assign cdbData      = cdb_data_q;

   // Data memory write port. Reads below see the pre-write value when
   // both hit the same address at the same edge.
   always_ff @(posedge clock) begin
      if (memWriteEnable) mem_q[memWriteAddr] <= memWriteData;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         cdb_tag_q  <= '0;
         cdb_dest_q <= '0;
         cdb_data_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (requestEnable && fifo_full) overflow_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (pop) begin
                  cur_tag_q  <= head.tag;
                  cur_dest_q <= head.dest;
                  cur_addr_q <= head.addr[ADDR_BITS-1:0];
                  cnt_q      <= CNT_INIT;
                  state_q    <= ACCESS;
               end
            end

            ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_ONE;
               end else begin
                  cdb_data_q <= mem_q[cur_addr_q];
                  cdb_tag_q  <= cur_tag_q;
                  cdb_dest_q <= cur_dest_q;
                  req_q      <= 1'b1;
                  state_q    <= BROADCAST;
               end
            end

            BROADCAST: begin
               if (cdbGrant) begin
                  req_q      <= 1'b0;
                  cdb_tag_q  <= '0;
                  cdb_dest_q <= '0;
                  cdb_data_q <= '0;
                  if (pop) begin
                     cur_tag_q  <= head.tag;
                     cur_dest_q <= head.dest;
                     cur_addr_q <= head.addr[ADDR_BITS-1:0];
                     cnt_q      <= CNT_INIT;
                     state_q    <= ACCESS;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_memory_unit.sv
module tb_load_memory_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        requestEnable;
   logic [2:0]  requestRegister;
   logic [15:0] requestAddress;
   logic [3:0]  requestTag;
   logic        requestReady;
   logic        memWriteEnable;
   logic [7:0]  memWriteAddr;
   logic [15:0] memWriteData;
   logic        cdbRequest;
   logic        cdbGrant;
   logic [3:0]  cdbTag;
   logic [2:0]  cdbDest;
   logic [15:0] cdbData;
   logic [2:0]  occupancy;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   load_memory_unit #(
      .FIFO_DEPTH  (4),
      .MEM_LATENCY (2),
      .ADDR_BITS   (8)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .requestEnable   (requestEnable),
      .requestRegister (requestRegister),
      .requestAddress  (requestAddress),
      .requestTag      (requestTag),
      .requestReady    (requestReady),
      .memWriteEnable  (memWriteEnable),
      .memWriteAddr    (memWriteAddr),
      .memWriteData    (memWriteData),
      .cdbRequest      (cdbRequest),
      .cdbGrant        (cdbGrant),
      .cdbTag          (cdbTag),
      .cdbDest         (cdbDest),
      .cdbData         (cdbData),
      .occupancy       (occupancy),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One active edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
      memWriteEnable = 1'b1;
      memWriteAddr   = a;
      memWriteData   = d;
      step();
      memWriteEnable = 1'b0;
   endtask

   task automatic push(input logic [3:0] t, input logic [2:0] r, input logic [15:0] a);
      requestEnable   = 1'b1;
      requestTag      = t;
      requestRegister = r;
      requestAddress  = a;
      step();
      requestEnable   = 1'b0;
   endtask

   task automatic wait_req(input int max, output int n);
      n = 0;
      while (!cdbRequest && n < max) begin
         step();
         n++;
      end
      check("wait_req_timeout", {31'b0, cdbRequest}, 32'd1);
   endtask

   initial begin
      int n;
      int nb;
      int peak;

      reset           = 1'b1;
      requestEnable   = 1'b0;
      requestRegister = '0;
      requestAddress  = '0;
      requestTag      = '0;
      memWriteEnable  = 1'b0;
      memWriteAddr    = '0;
      memWriteData    = '0;
      cdbGrant        = 1'b0;
      step();
      step();
      reset = 1'b0;

      // Reset state
      check("rst_cdbRequest", {31'b0, cdbRequest}, 32'd0);
      check("rst_cdbTag", {28'b0, cdbTag}, 32'd0);
      check("rst_cdbData", {16'b0, cdbData}, 32'd0);
      check("rst_occupancy", {29'b0, occupancy}, 32'd0);
      check("rst_requestReady", {31'b0, requestReady}, 32'd1);
      check("rst_overflow", {31'b0, overflow}, 32'd0);

      // Single load latency: push at edge 0, request visible after edge 3
      mem_write(8'h05, 16'hBEEF);
      cdbGrant = 1'b1;
      push(4'h9, 3'd3, 16'h0005);
      check("t1_occ_e0", {29'b0, occupancy}, 32'd1);
      check("t1_req_e0", {31'b0, cdbRequest}, 32'd0);
      step();
      check("t1_occ_e1", {29'b0, occupancy}, 32'd0);
      check("t1_req_e1", {31'b0, cdbRequest}, 32'd0);
      step();
      check("t1_req_e2", {31'b0, cdbRequest}, 32'd0);
      step();
      check("t1_req_e3", {31'b0, cdbRequest}, 32'd1);
      check("t1_tag_e3", {28'b0, cdbTag}, 32'h9);
      check("t1_dest_e3", {29'b0, cdbDest}, 32'd3);
      check("t1_data_e3", {16'b0, cdbData}, 32'hBEEF);
      step();
      check("t1_req_e4", {31'b0, cdbRequest}, 32'd0);
      check("t1_data_e4", {16'b0, cdbData}, 32'd0);
      check("t1_tag_e4", {28'b0, cdbTag}, 32'd0);

      // Three back-to-back loads, immediate grant: broadcasts at 3, 6, 9
      mem_write(8'h10, 16'hA001);
      mem_write(8'h11, 16'hA002);
      mem_write(8'h12, 16'hA003);
      nb = 0;
      peak = 0;
      for (int i = 0; i < 12; i++) begin
         if (i < 3) begin
            requestEnable   = 1'b1;
            requestTag      = 4'(8 + i);
            requestRegister = 3'(i + 1);
            requestAddress  = 16'(16'h0010 + i);
         end else begin
            requestEnable = 1'b0;
         end
         step();
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (cdbRequest) begin
            check("t2_cycle", i, 3 + 3 * nb);
            check("t2_tag", {28'b0, cdbTag}, 32'(8 + nb));
            check("t2_dest", {29'b0, cdbDest}, 32'(nb + 1));
            check("t2_data", {16'b0, cdbData}, 32'(16'hA001 + nb));
            nb++;
         end
      end
      requestEnable = 1'b0;
      check("t2_count", nb, 3);
      check("t2_peak_occ", peak, 2);

      // Grant withheld: outputs hold, FIFO fills, extra push overflows
      for (int i = 0; i < 6; i++) mem_write(8'(8'h20 + i), 16'(16'hC000 + i));
      cdbGrant = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 6) begin
            requestEnable   = 1'b1;
            requestTag      = 4'(8 + i);
            requestRegister = 3'(i);
            requestAddress  = 16'(16'h0020 + i);
         end else begin
            requestEnable = 1'b0;
         end
         step();
         if (i >= 3) begin
            check("t3_hold_req", {31'b0, cdbRequest}, 32'd1);
            check("t3_hold_tag", {28'b0, cdbTag}, 32'h8);
            check("t3_hold_dest", {29'b0, cdbDest}, 32'd0);
            check("t3_hold_data", {16'b0, cdbData}, 32'hC000);
         end
         if (i == 4) begin
            check("t3_occ_full", {29'b0, occupancy}, 32'd4);
            check("t3_ready_full", {31'b0, requestReady}, 32'd0);
            check("t3_ovf_before", {31'b0, overflow}, 32'd0);
         end
         if (i == 5) begin
            check("t3_ovf_after", {31'b0, overflow}, 32'd1);
            check("t3_occ_after", {29'b0, occupancy}, 32'd4);
         end
      end
      requestEnable = 1'b0;
      cdbGrant = 1'b1;
      nb = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (cdbRequest) begin
            check("t3_drain_tag", {28'b0, cdbTag}, 32'(9 + nb));
            check("t3_drain_data", {16'b0, cdbData}, 32'(16'hC001 + nb));
            nb++;
         end
      end
      check("t3_drain_count", nb, 4);
      check("t3_occ_empty", {29'b0, occupancy}, 32'd0);
      check("t3_ovf_sticky", {31'b0, overflow}, 32'd1);

      // Upper address bits ignored
      mem_write(8'h05, 16'h1234);
      push(4'hE, 3'd2, 16'hFF05);
      wait_req(10, n);
      check("t4_data", {16'b0, cdbData}, 32'h1234);
      check("t4_tag", {28'b0, cdbTag}, 32'hE);
      check("t4_dest", {29'b0, cdbDest}, 32'd2);
      step();
      step();

      // Reset during ACCESS with two entries queued
      for (int i = 0; i < 3; i++) push(4'(8 + i), 3'(i), 16'(16'h0010 + i));
      check("t5_occ_pre", {29'b0, occupancy}, 32'd2);
      check("t5_req_pre", {31'b0, cdbRequest}, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_req", {31'b0, cdbRequest}, 32'd0);
      check("t5_occ", {29'b0, occupancy}, 32'd0);
      check("t5_ovf", {31'b0, overflow}, 32'd0);
      check("t5_ready", {31'b0, requestReady}, 32'd1);
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (cdbRequest) nb++;
      end
      check("t5_no_bcast", nb, 0);

      // Write colliding with the ACCESS read returns old data
      mem_write(8'h07, 16'h1111);
      push(4'hA, 3'd6, 16'h0007);
      step();
      step();
      memWriteEnable = 1'b1;
      memWriteAddr   = 8'h07;
      memWriteData   = 16'hAAAA;
      step();
      memWriteEnable = 1'b0;
      check("t6_req", {31'b0, cdbRequest}, 32'd1);
      check("t6_old_data", {16'b0, cdbData}, 32'h1111);
      step();
      push(4'hB, 3'd7, 16'h0007);
      wait_req(10, n);
      check("t6_new_data", {16'b0, cdbData}, 32'hAAAA);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_memory_unit.md
Name: load_memory_unit

Overview:
Memory-access stage directly downstream of the load reservation station in the Tomasulo core. Accepts issued load requests (destination register, effective address, station tag) and buffers them in an in-order FIFO. Each request is serviced by a fixed-latency read of a local data memory. The loaded value is broadcast on the common data bus (CDB) under an arbiter request/grant handshake, so waiting stations and the register status table can capture it.

Parameters:
FIFO_DEPTH, 4, request buffer entries (power of two, >=2)
MEM_LATENCY, 2, cycles spent in ACCESS per load (>=1)
ADDR_BITS, 8, data-memory index width (memory holds 2^ADDR_BITS x 16-bit words)

Ports:
clock  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high
requestEnable  input  1  push request this cycle
requestRegister  input  3  destination register id
requestAddress  input  16  effective address; only [ADDR_BITS-1:0] used, upper bits ignored
requestTag  input  4  issuing station tag ({1'b1, slot})
requestReady  output  1  FIFO not full
memWriteEnable  input  1  preload/store write port enable
memWriteAddr  input  ADDR_BITS  write index
memWriteData  input  16  write data
cdbRequest  output  1  result pending, asking arbiter for bus
cdbGrant  input  1  arbiter grant, sampled while cdbRequest=1
cdbTag  output  4  producing station tag
cdbDest  output  3  destination register id
cdbData  output  16  loaded value
occupancy  output  clog2(FIFO_DEPTH)+1  FIFO entries in use
overflow  output  1  sticky: push attempted while full

Behaviour:
- Reset (sync, high): FIFO emptied, state IDLE, latency counter 0, overflow=0, cdbRequest=0, cdbTag/cdbDest/cdbData=0, occupancy=0, requestReady=1. Memory array contents are not reset. Reset mid-access or mid-broadcast discards the in-flight load with no CDB transfer.
- Push: at an edge with requestEnable=1 and FIFO not full, {tag, register, address} is enqueued. requestReady is derived from registered occupancy. A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
- FIFO order is strict; pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop when not full leaves occupancy unchanged.
- FSM states:
  - IDLE: if FIFO non-empty, pop head, latch it, set counter=MEM_LATENCY-1, go to ACCESS.
  - ACCESS: if counter>0, decrement. If counter==0, read mem[addr] into cdbData, drive cdbTag/cdbDest from the latched entry, set cdbRequest=1, go to BROADCAST.
  - BROADCAST: hold cdbRequest and all cdb* outputs stable until an edge with cdbGrant=1. At that edge, clear cdbRequest. If the FIFO is non-empty, pop the next entry and go directly to ACCESS; otherwise go to IDLE.
- Latency: a request pushed at edge E into an empty FIFO while IDLE has cdbRequest visible after edge E+1+MEM_LATENCY (default E+3). Back-to-back loads have a throughput of one per MEM_LATENCY+1 cycles when grant is immediate.
- cdbGrant while cdbRequest=0 is ignored.
- Memory write at the same edge as the ACCESS read of the same address: the read returns the old data.
- cdb* outputs return to 0 when cdbRequest deasserts.

Decomposition:
- Shared package (tomasulo_pkg): TAG_W=4, REG_W=3, DATA_W=16, load-request struct {tag, reg, addr}, FSM state enum {IDLE, ACCESS, BROADCAST}.
- One sub-module: load_request_fifo (parameterised depth; push/pop/full/empty/occupancy). The FSM, counter, memory array and CDB outputs stay in load_memory_unit.

Test Plan:
- Preload mem[0x05]=0xBEEF; push tag=0x9, reg=3, addr=0x0005 at edge 0; hold cdbGrant=1 -> cdbRequest=1 with tag 0x9, dest 3, data 0xBEEF visible after edge 3, cleared after edge 4.
- Push 3 loads on consecutive edges, grant immediately -> broadcasts in push order, spaced 3 cycles apart; occupancy peaks at 2.
- Hold cdbGrant=0 for 5 cycles during BROADCAST -> cdb* outputs stable, FIFO fills to 4, requestReady=0; a 5th push is dropped and overflow=1.
- requestAddress=0xFF05 with mem[0x05]=0x1234 -> cdbData=0x1234 (upper address bits ignored).
- Assert reset during ACCESS with 2 entries queued -> next cycle cdbRequest=0, occupancy=0, overflow=0, and no broadcast occurs afterwards.
- memWrite 0xAAAA to addr 0x07 on the same edge the ACCESS of 0x07 completes (old value 0x1111) -> cdbData=0x1111.
